// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte-lane write enables, 1/2-cycle read latency,
// selectable read-during-write policy and an optional post-reset array clear.
module ram_dp_be #(
  parameter int unsigned ADDR_SIZE      = 10,
  parameter int unsigned WORD_SIZE      = 8,
  parameter int unsigned LANES          = 1,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] w_addr,
  input  logic [WORD_SIZE-1:0] w_data,
  input  logic                 we,
  input  logic [LANES-1:0]     w_be,
  input  logic [ADDR_SIZE-1:0] r_addr,
  input  logic                 re,
  output logic [WORD_SIZE-1:0] r_data,
  output logic                 r_valid,
  output logic                 init_busy
);

  localparam int unsigned LW    = WORD_SIZE / LANES;
  localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  if ((WORD_SIZE % LANES) != 0) begin : g_chk_lanes
    $error("ram_dp_be: WORD_SIZE must be a multiple of LANES");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_chk_lat
    $error("ram_dp_be: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE > 1) begin : g_chk_rdw
    $error("ram_dp_be: RDW_MODE must be 0 or 1");
  end

  logic [0:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] clr_cnt_q, clr_cnt_d;
  logic [WORD_SIZE-1:0] d1_q, d1_d;
  logic                 v1_q, v1_d;

  logic                 running;
  logic                 rd_fire;
  logic                 wr_en;
  logic [LANES-1:0]     wr_be;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic [WORD_SIZE-1:0] rd_word;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  assign running   = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_CLEAR);
  assign rd_fire   = running && re;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_SIZE'(1);
      if (clr_cnt_q == '1) state_d = ST_RUN;
    end
  end

  // The clear sweep shares the single write port; user writes are dropped meanwhile.
  always_comb begin
    if (running) begin
      wr_en   = we;
      wr_be   = w_be;
      wr_addr = w_addr;
      wr_data = w_data;
    end else begin
      wr_en   = 1'b1;
      wr_be   = '1;
      wr_addr = clr_cnt_q;
      wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
      end
    end
  end

  // Write-first merge is per lane: only enabled lanes forward the incoming data.
  always_comb begin
    rd_word = mem[r_addr];
    if ((RDW_MODE == 1) && we && (w_addr == r_addr)) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (w_be[i]) rd_word[i*LW +: LW] = w_data[i*LW +: LW];
      end
    end
  end

  always_comb begin
    v1_d = rd_fire;
    d1_d = rd_fire ? rd_word : d1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      clr_cnt_q <= '0;
      d1_q      <= '0;
      v1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      d1_q      <= d1_d;
      v1_q      <= v1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [WORD_SIZE-1:0] d2_q;
    logic                 v2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign r_data  = d2_q;
    assign r_valid = v2_q;
  end else begin : g_lat1
    assign r_data  = d1_q;
    assign r_valid = v1_q;
  end

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (latency 1 / old-data and latency 2 /
// merged-data) share stimulus; a reference array and per-instance queues give expected reads.
module tb_ram_dp_be;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          we;
  logic [NL-1:0] w_be;
  logic [AW-1:0] r_addr;
  logic          re;

  logic [DW-1:0] rd_a, rd_b;
  logic          rv_a, rv_b;
  logic          busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] last_a, last_b;
  int            clr_left;
  bit            a_vexp, b_vexp, b_pend;

  always #5 clk = ~clk;

  ram_dp_be #(
    .ADDR_SIZE(AW), .WORD_SIZE(DW), .LANES(NL),
    .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .w_addr(w_addr), .w_data(w_data), .we(we), .w_be(w_be),
    .r_addr(r_addr), .re(re), .r_data(rd_a), .r_valid(rv_a), .init_busy(busy_a)
  );

  ram_dp_be #(
    .ADDR_SIZE(AW), .WORD_SIZE(DW), .LANES(NL),
    .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .w_addr(w_addr), .w_data(w_data), .we(we), .w_be(w_be),
    .r_addr(r_addr), .re(re), .r_data(rd_b), .r_valid(rv_b), .init_busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    clr_left = DEPTH;
    b_pend   = 1'b0;
    last_a   = '0;
    last_b   = '0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Assert reset mid-cycle, check the async effect, release before the next edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("rst_valid_a", 32'(rv_a), 32'd0);
    chk("rst_data_a", rd_a, 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_valid_b", 32'(rv_b), 32'd0);
    chk("rst_data_b", rd_b, 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd1);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic we_i, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NL-1:0] be, input logic re_i, input logic [AW-1:0] ra);
    bit            run;
    logic [DW-1:0] old_w, mrg_w, exp_w;
    we = we_i; w_addr = wa; w_data = wd; w_be = be; re = re_i; r_addr = ra;
    @(posedge clk);
    run = (clr_left == 0);
    if (!run) clr_left--;
    a_vexp = run && re_i;
    b_vexp = b_pend;
    b_pend = run && re_i;
    if (run && re_i) begin
      old_w = model[ra];
      mrg_w = old_w;
      if (we_i && (wa == ra)) begin
        for (int i = 0; i < NL; i++) if (be[i]) mrg_w[i*8 +: 8] = wd[i*8 +: 8];
      end
      qa.push_back(old_w);
      qb.push_back(mrg_w);
    end
    if (run && we_i) begin
      for (int i = 0; i < NL; i++) if (be[i]) model[wa][i*8 +: 8] = wd[i*8 +: 8];
    end
    #1;
    chk("busy_a", 32'(busy_a), 32'(clr_left != 0));
    chk("busy_b", 32'(busy_b), 32'(clr_left != 0));
    chk("valid_a", 32'(rv_a), 32'(a_vexp));
    chk("valid_b", 32'(rv_b), 32'(b_vexp));
    if (a_vexp) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb_a: observed empty queue expected entry");
      end else begin
        exp_w = qa.pop_front();
        last_a = exp_w;
      end
    end
    if (b_vexp) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb_b: observed empty queue expected entry");
      end else begin
        exp_w = qb.pop_front();
        last_b = exp_w;
      end
    end
    chk("data_a", rd_a, last_a);
    chk("data_b", rd_b, last_b);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; w_addr = '0; w_data = '0; w_be = '0; re = 1'b0; r_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // Clear: writes and reads attempted during the sweep must be ignored
    for (int k = 0; k < DEPTH; k++) step(1'b1, AW'(k), 32'hFFFF_FFFF, 4'hF, 1'b1, AW'(k));
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, '0, '0, 1'b1, AW'(k));
    idle();

    // Lane enables
    step(1'b1, 4'd5, 32'hAABB_CCDD, 4'b1111, 1'b0, '0);
    step(1'b1, 4'd5, 32'h1122_3344, 4'b0101, 1'b0, '0);
    step(1'b1, 4'd5, 32'h0000_0000, 4'b0000, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd5);
    idle();

    // Latency and back-to-back throughput
    step(1'b1, 4'd0, 32'h10, 4'hF, 1'b0, '0);
    step(1'b1, 4'd1, 32'h11, 4'hF, 1'b0, '0);
    step(1'b1, 4'd2, 32'h12, 4'hF, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd1);
    step(1'b0, '0, '0, '0, 1'b1, 4'd2);
    idle();
    idle();

    // Read during write, same and different addresses
    step(1'b1, 4'd3, 32'h55, 4'hF, 1'b0, '0);
    step(1'b1, 4'd3, 32'h99, 4'hF, 1'b1, 4'd3);
    step(1'b0, '0, '0, '0, 1'b1, 4'd3);
    step(1'b1, 4'd3, 32'hDEAD_BEEF, 4'b0011, 1'b1, 4'd3);
    step(1'b1, 4'd7, 32'h7777_7777, 4'hF, 1'b1, 4'd3);
    step(1'b0, '0, '0, '0, 1'b1, 4'd7);
    idle();

    // Hold: r_data keeps the last word while re is low
    step(1'b0, '0, '0, '0, 1'b1, 4'd2);
    step(1'b1, 4'd2, 32'hCAFE_F00D, 4'hF, 1'b0, 4'd2);
    repeat (4) idle();

    // Reset mid-clear restarts the full sweep
    pulse_reset();
    repeat (7) idle();
    pulse_reset();
    for (int k = 0; k < DEPTH; k++) idle();
    step(1'b0, '0, '0, '0, 1'b1, 4'd5);
    step(1'b0, '0, '0, '0, 1'b1, 4'd2);
    step(1'b0, '0, '0, '0, 1'b1, 4'd15);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
